// File: rtl/pc_stack.sv
// Program counter with a hardware return-address stack: increment, jump, call, return.
// Optional macro PC_STACK_TRAP_EN redirects pc_out to TRAP_VEC on stack overflow/underflow.
module pc_stack #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned BUS_W     = 16,
    parameter int unsigned LOAD_W    = 8,
    parameter int unsigned RESET_VEC = 10,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned TRAP_VEC  = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pc_inc,
    input  logic                       pc_write,
    input  logic                       pc_call,
    input  logic                       pc_ret,
    input  logic [BUS_W-1:0]           bus,
    output logic [ADDR_W-1:0]          pc_out,
    output logic [$clog2(DEPTH+1)-1:0] stk_depth,
    output logic                       stk_empty,
    output logic                       stk_full,
    output logic                       stk_err
);

    localparam int unsigned DEPTH_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               empty_q, empty_d;
    logic               full_q, full_d;
    logic               err_q, err_d;
    logic [ADDR_W-1:0]  ras_q [DEPTH];

    logic [ADDR_W-1:0]  target_s;
    logic [ADDR_W-1:0]  pc_plus1_s;
    logic [ADDR_W-1:0]  err_pc_s;
    logic [PTR_W-1:0]   push_idx_s;
    logic [PTR_W-1:0]   pop_idx_s;
    logic               push_en_s;
    logic               at_full_s;
    logic               at_empty_s;

    assign target_s   = ADDR_W'(bus[LOAD_W-1:0]);
    assign pc_plus1_s = pc_q + ADDR_W'(1);
    assign at_full_s  = (depth_q == DEPTH_W'(DEPTH));
    assign at_empty_s = (depth_q == DEPTH_W'(0));
    assign push_idx_s = PTR_W'(depth_q);
    assign pop_idx_s  = PTR_W'(depth_q - DEPTH_W'(1));

`ifdef PC_STACK_TRAP_EN
    assign err_pc_s = ADDR_W'(TRAP_VEC);
`else
    assign err_pc_s = pc_q;
`endif

    // Next-state decode with priority ret > call > write > inc > hold
    always_comb begin
        pc_d      = pc_q;
        depth_d   = depth_q;
        err_d     = err_q;
        push_en_s = 1'b0;
        if (pc_ret) begin
            if (at_empty_s) begin
                err_d = 1'b1;
                pc_d  = err_pc_s;
            end else begin
                pc_d    = ras_q[pop_idx_s];
                depth_d = depth_q - DEPTH_W'(1);
            end
        end else if (pc_call) begin
            if (at_full_s) begin
                err_d = 1'b1;
                pc_d  = err_pc_s;
            end else begin
                push_en_s = 1'b1;
                pc_d      = target_s;
                depth_d   = depth_q + DEPTH_W'(1);
            end
        end else if (pc_write) begin
            pc_d = target_s;
        end else if (pc_inc) begin
            pc_d = pc_plus1_s;
        end else begin
            pc_d = pc_q;
        end
        empty_d = (depth_d == DEPTH_W'(0));
        full_d  = (depth_d == DEPTH_W'(DEPTH));
    end

    // Control state registers; reset empties the stack and clears the sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= ADDR_W'(RESET_VEC);
            depth_q <= DEPTH_W'(0);
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            depth_q <= depth_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            err_q   <= err_d;
        end
    end

    // Return-address storage; a push in the reset cycle is suppressed
    always_ff @(posedge clk) begin
        if (push_en_s && !rst) begin
            ras_q[push_idx_s] <= pc_plus1_s;
        end
    end

    assign pc_out    = pc_q;
    assign stk_depth = depth_q;
    assign stk_empty = empty_q;
    assign stk_full  = full_q;
    assign stk_err   = err_q;

endmodule

// File: tb/tb_pc_stack.sv
// Directed self-checking bench for pc_stack at default parameters.
module tb_pc_stack;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pc_inc = 1'b0;
    logic        pc_write = 1'b0;
    logic        pc_call = 1'b0;
    logic        pc_ret = 1'b0;
    logic [15:0] bus = 16'h0000;
    logic [15:0] pc_out;
    logic [2:0]  stk_depth;
    logic        stk_empty;
    logic        stk_full;
    logic        stk_err;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [15:0] exp_err_pc;

    pc_stack dut (
        .clk(clk), .rst(rst), .pc_inc(pc_inc), .pc_write(pc_write),
        .pc_call(pc_call), .pc_ret(pc_ret), .bus(bus), .pc_out(pc_out),
        .stk_depth(stk_depth), .stk_empty(stk_empty), .stk_full(stk_full),
        .stk_err(stk_err)
    );

    always #5 clk = ~clk;

    // Apply one cycle of strobes, then sample 1 time unit after the edge.
    task automatic cyc(input logic r, input logic i, input logic w,
                       input logic c, input logic t, input logic [15:0] b);
        rst = r; pc_inc = i; pc_write = w; pc_call = c; pc_ret = t; bus = b;
        @(posedge clk);
        #1;
        rst = 1'b0; pc_inc = 1'b0; pc_write = 1'b0; pc_call = 1'b0; pc_ret = 1'b0;
    endtask

    task automatic test_reset;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        total_cnt++; if (pc_out !== 16'd10) $display("FAIL reset_pc got %h want %h", pc_out, 16'd10); else pass_cnt++;
        total_cnt++; if (stk_depth !== 3'd0) $display("FAIL reset_depth got %0d want 0", stk_depth); else pass_cnt++;
        total_cnt++; if (stk_empty !== 1'b1 || stk_full !== 1'b0) $display("FAIL reset_flags got e=%b f=%b want e=1 f=0", stk_empty, stk_full); else pass_cnt++;
        total_cnt++; if (stk_err !== 1'b0) $display("FAIL reset_err got %b want 0", stk_err); else pass_cnt++;
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        total_cnt++; if (pc_out !== 16'd13) $display("FAIL inc3 got %h want %h", pc_out, 16'd13); else pass_cnt++;
    endtask

    task automatic test_write;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'hAB37);
        total_cnt++; if (pc_out !== 16'h0037) $display("FAIL write_zext got %h want 0037", pc_out); else pass_cnt++;
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'hFF12);
        total_cnt++; if (pc_out !== 16'h0012) $display("FAIL write_over_inc got %h want 0012", pc_out); else pass_cnt++;
    endtask

    task automatic test_wrap;
        pc_inc = 1'b1;
        repeat (16'hFFFF - 16'h0012) @(posedge clk);
        #1;
        pc_inc = 1'b0;
        total_cnt++; if (pc_out !== 16'hFFFF) $display("FAIL reach_ffff got %h want ffff", pc_out); else pass_cnt++;
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0005);
        total_cnt++; if (pc_out !== 16'h0005 || stk_depth !== 3'd1) $display("FAIL call_at_ffff got pc=%h d=%0d want pc=0005 d=1", pc_out, stk_depth); else pass_cnt++;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        total_cnt++; if (pc_out !== 16'h0000) $display("FAIL ret_wrapped got %h want 0000", pc_out); else pass_cnt++;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h00FF);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        pc_inc = 1'b1;
        repeat (16'hFFFF - 16'h00FF) @(posedge clk);
        #1;
        pc_inc = 1'b0;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        total_cnt++; if (pc_out !== 16'h0000 || stk_err !== 1'b0) $display("FAIL inc_wrap got pc=%h err=%b want pc=0000 err=0", pc_out, stk_err); else pass_cnt++;
    endtask

    task automatic test_call_ret;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0014);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0040);
        total_cnt++; if (pc_out !== 16'h0040 || stk_depth !== 3'd1) $display("FAIL call1 got pc=%h d=%0d want pc=0040 d=1", pc_out, stk_depth); else pass_cnt++;
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0060);
        total_cnt++; if (pc_out !== 16'h0060 || stk_depth !== 3'd2) $display("FAIL call2 got pc=%h d=%0d want pc=0060 d=2", pc_out, stk_depth); else pass_cnt++;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        total_cnt++; if (pc_out !== 16'h0041 || stk_depth !== 3'd1) $display("FAIL ret1 got pc=%h d=%0d want pc=0041 d=1", pc_out, stk_depth); else pass_cnt++;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        total_cnt++; if (pc_out !== 16'd21 || stk_empty !== 1'b1) $display("FAIL ret2 got pc=%h e=%b want pc=0015 e=1", pc_out, stk_empty); else pass_cnt++;
    endtask

    task automatic test_overflow;
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0010);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0020);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0030);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0050);
        total_cnt++; if (stk_full !== 1'b1 || stk_depth !== 3'd4 || stk_err !== 1'b0) $display("FAIL full got f=%b d=%0d err=%b want f=1 d=4 err=0", stk_full, stk_depth, stk_err); else pass_cnt++;
        exp_err_pc = 16'h0050;
`ifdef PC_STACK_TRAP_EN
        exp_err_pc = 16'h0000;
`endif
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0070);
        total_cnt++; if (stk_err !== 1'b1 || stk_depth !== 3'd4) $display("FAIL overflow got err=%b d=%0d want err=1 d=4", stk_err, stk_depth); else pass_cnt++;
        total_cnt++; if (pc_out !== exp_err_pc) $display("FAIL overflow_pc got %h want %h", pc_out, exp_err_pc); else pass_cnt++;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        total_cnt++; if (pc_out !== 16'h0031 || stk_full !== 1'b0) $display("FAIL unwind1 got pc=%h f=%b want pc=0031 f=0", pc_out, stk_full); else pass_cnt++;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        total_cnt++; if (pc_out !== 16'h0021) $display("FAIL unwind2 got %h want 0021", pc_out); else pass_cnt++;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        total_cnt++; if (pc_out !== 16'h0011) $display("FAIL unwind3 got %h want 0011", pc_out); else pass_cnt++;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        total_cnt++; if (pc_out !== 16'h0016 || stk_empty !== 1'b1 || stk_err !== 1'b1) $display("FAIL unwind4 got pc=%h e=%b err=%b want pc=0016 e=1 err=1", pc_out, stk_empty, stk_err); else pass_cnt++;
    endtask

    task automatic test_underflow;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        total_cnt++; if (stk_err !== 1'b0) $display("FAIL err_cleared got %b want 0", stk_err); else pass_cnt++;
        exp_err_pc = 16'd10;
`ifdef PC_STACK_TRAP_EN
        exp_err_pc = 16'h0000;
`endif
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        total_cnt++; if (stk_err !== 1'b1 || stk_depth !== 3'd0 || pc_out !== exp_err_pc) $display("FAIL underflow got err=%b d=%0d pc=%h want err=1 d=0 pc=%h", stk_err, stk_depth, pc_out, exp_err_pc); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0040);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0077);
        total_cnt++; if (pc_out !== 16'd11 || stk_depth !== 3'd0 || stk_err !== 1'b0) $display("FAIL ret_call_pop got pc=%h d=%0d err=%b want pc=000b d=0 err=0", pc_out, stk_depth, stk_err); else pass_cnt++;
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0040);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0055);
        total_cnt++; if (pc_out !== 16'd10 || stk_depth !== 3'd0 || stk_empty !== 1'b1) $display("FAIL rst_with_call got pc=%h d=%0d e=%b want pc=000a d=0 e=1", pc_out, stk_depth, stk_empty); else pass_cnt++;
        exp_err_pc = 16'd10;
`ifdef PC_STACK_TRAP_EN
        exp_err_pc = 16'h0000;
`endif
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        total_cnt++; if (stk_err !== 1'b1 || pc_out !== exp_err_pc) $display("FAIL no_push_on_rst got err=%b pc=%h want err=1 pc=%h", stk_err, pc_out, exp_err_pc); else pass_cnt++;
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_write();
        test_wrap();
        test_call_ret();
        test_overflow();
        test_underflow();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
